// File: rtl/sysbus_arbiter.sv
// Two-master system bus arbiter with slave address decode and read steering.
// Master 0 has priority; master 1 is guaranteed a grant after STARVE_LIMIT denials.
module sysbus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_en_i,
  input  logic        m0_rdwr_i,
  input  logic [3:0]  m0_mask_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wr_data_i,
  output logic        m0_gnt_o,
  output logic [31:0] m0_rd_data_o,
  output logic        m0_rd_valid_o,
  input  logic        m1_en_i,
  input  logic        m1_rdwr_i,
  input  logic [3:0]  m1_mask_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wr_data_i,
  output logic        m1_gnt_o,
  output logic [31:0] m1_rd_data_o,
  output logic        m1_rd_valid_o,
  output logic        bus_rdwr_o,
  output logic [3:0]  bus_mask_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wr_data_o,
  output logic        mem_en_o,
  output logic        gemm_en_o,
  output logic        uart_sel_o,
  input  logic [31:0] mem_rd_data_i,
  input  logic [31:0] gemm_rd_data_i,
  input  logic [31:0] uart_rd_data_i
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] SLV_MEM  = 2'd0;
  localparam logic [1:0] SLV_GEMM = 2'd1;
  localparam logic [1:0] SLV_UART = 2'd2;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             own_q, own_d;
  logic [1:0]       slv_q, slv_d;

  logic        m0_gnt, m1_gnt, gnt_any;
  logic [31:0] addr;
  logic [31:0] rd_mux;

  assign m1_gnt  = !rst_i && m1_en_i && (!m0_en_i || (cnt_q == LIMIT));
  assign m0_gnt  = !rst_i && m0_en_i && !m1_gnt;
  assign gnt_any = m0_gnt || m1_gnt;

  assign addr          = m1_gnt ? m1_addr_i    : m0_addr_i;
  assign bus_rdwr_o    = m1_gnt ? m1_rdwr_i    : m0_rdwr_i;
  assign bus_mask_o    = m1_gnt ? m1_mask_i    : m0_mask_i;
  assign bus_wr_data_o = m1_gnt ? m1_wr_data_i : m0_wr_data_i;
  assign bus_addr_o    = {addr[31:2], 2'b00};

  always_comb begin
    slv_d = SLV_MEM;
    if (addr[31:28] == 4'h9) slv_d = SLV_GEMM;
    else if (addr[31:28] == 4'h8) slv_d = SLV_UART;
  end

  assign mem_en_o   = gnt_any && (slv_d == SLV_MEM);
  assign gemm_en_o  = gnt_any && (slv_d == SLV_GEMM);
  assign uart_sel_o = gnt_any && (slv_d == SLV_UART);

  assign m0_gnt_o = m0_gnt;
  assign m1_gnt_o = m1_gnt;

  // Any cycle without an m1 request, or with an m1 grant, restarts the count
  always_comb begin
    cnt_d = cnt_q;
    if (!m1_en_i || m1_gnt) cnt_d = '0;
    else if (cnt_q != LIMIT) cnt_d = cnt_q + CNT_W'(1);
  end

  assign vld_d = gnt_any && !bus_rdwr_o;
  assign own_d = m1_gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      vld_q <= 1'b0;
      own_q <= 1'b0;
      slv_q <= SLV_MEM;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      if (vld_d) begin
        own_q <= own_d;
        slv_q <= slv_d;
      end
    end
  end

  always_comb begin
    rd_mux = mem_rd_data_i;
    if (slv_q == SLV_GEMM) rd_mux = gemm_rd_data_i;
    else if (slv_q == SLV_UART) rd_mux = uart_rd_data_i;
  end

  assign m0_rd_valid_o = !rst_i && vld_q && !own_q;
  assign m1_rd_valid_o = !rst_i && vld_q && own_q;
  assign m0_rd_data_o  = m0_rd_valid_o ? rd_mux : '0;
  assign m1_rd_data_o  = m1_rd_valid_o ? rd_mux : '0;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: vector table plus contention and reset sequences,
// read responses tracked through a scoreboard queue.
module tb_sysbus_arbiter;

  localparam logic [31:0] MEM_D  = 32'h1122_3344;
  localparam logic [31:0] GEMM_D = 32'hA5A5_A5A5;
  localparam logic [31:0] UART_D = 32'h0000_005A;

  localparam logic [2:0] S_NONE = 3'b000;
  localparam logic [2:0] S_MEM  = 3'b001;
  localparam logic [2:0] S_GEMM = 3'b010;
  localparam logic [2:0] S_UART = 3'b100;

  typedef struct {
    logic        rst;
    logic        m0_en;
    logic        m0_rw;
    logic [3:0]  m0_mask;
    logic [31:0] m0_addr;
    logic [31:0] m0_wd;
    logic        m1_en;
    logic        m1_rw;
    logic [3:0]  m1_mask;
    logic [31:0] m1_addr;
    logic [31:0] m1_wd;
    logic        e_g0;
    logic        e_g1;
    logic [2:0]  e_sel;
    logic [31:0] e_addr;
  } vec_t;

  typedef struct {
    logic        own;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_en = 1'b0, m0_rdwr = 1'b0;
  logic [3:0]  m0_mask = '0;
  logic [31:0] m0_addr = '0, m0_wr_data = '0;
  logic        m1_en = 1'b0, m1_rdwr = 1'b0;
  logic [3:0]  m1_mask = '0;
  logic [31:0] m1_addr = '0, m1_wr_data = '0;
  logic        m0_gnt, m0_rd_valid, m1_gnt, m1_rd_valid;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic        bus_rdwr;
  logic [3:0]  bus_mask;
  logic [31:0] bus_addr, bus_wr_data;
  logic        mem_en, gemm_en, uart_sel;
  logic [31:0] mem_rd_data = MEM_D;
  logic [31:0] gemm_rd_data = GEMM_D;
  logic [31:0] uart_rd_data = UART_D;

  int n_cmp = 0;
  int n_err = 0;
  resp_t sb[$];
  vec_t tbl[18];

  always #5 clk = ~clk;

  sysbus_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_en_i(m0_en), .m0_rdwr_i(m0_rdwr), .m0_mask_i(m0_mask),
    .m0_addr_i(m0_addr), .m0_wr_data_i(m0_wr_data),
    .m0_gnt_o(m0_gnt), .m0_rd_data_o(m0_rd_data), .m0_rd_valid_o(m0_rd_valid),
    .m1_en_i(m1_en), .m1_rdwr_i(m1_rdwr), .m1_mask_i(m1_mask),
    .m1_addr_i(m1_addr), .m1_wr_data_i(m1_wr_data),
    .m1_gnt_o(m1_gnt), .m1_rd_data_o(m1_rd_data), .m1_rd_valid_o(m1_rd_valid),
    .bus_rdwr_o(bus_rdwr), .bus_mask_o(bus_mask),
    .bus_addr_o(bus_addr), .bus_wr_data_o(bus_wr_data),
    .mem_en_o(mem_en), .gemm_en_o(gemm_en), .uart_sel_o(uart_sel),
    .mem_rd_data_i(mem_rd_data), .gemm_rd_data_i(gemm_rd_data),
    .uart_rd_data_i(uart_rd_data)
  );

  function automatic vec_t mk(
    input logic rs,
    input logic e0, input logic rw0, input logic [3:0] mk0, input logic [31:0] a0,
    input logic e1, input logic rw1, input logic [3:0] mk1, input logic [31:0] a1,
    input logic g0, input logic g1, input logic [2:0] sel, input logic [31:0] ea);
    vec_t v;
    v.rst = rs;
    v.m0_en = e0; v.m0_rw = rw0; v.m0_mask = mk0; v.m0_addr = a0;
    v.m0_wd = ~a0;
    v.m1_en = e1; v.m1_rw = rw1; v.m1_mask = mk1; v.m1_addr = a1;
    v.m1_wd = a1 ^ 32'h5555_AAAA;
    v.e_g0 = g0; v.e_g1 = g1; v.e_sel = sel; v.e_addr = ea;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, 4'h0, 32'h0, 0, 0, 4'h0, 32'h0, 0, 0, S_NONE, 32'h0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    resp_t r;
    logic rw, gnt;
    logic [3:0] mk_e;
    logic [31:0] wd_e;
    @(posedge clk);
    #1;
    rst = v.rst;
    m0_en = v.m0_en; m0_rdwr = v.m0_rw; m0_mask = v.m0_mask;
    m0_addr = v.m0_addr; m0_wr_data = v.m0_wd;
    m1_en = v.m1_en; m1_rdwr = v.m1_rw; m1_mask = v.m1_mask;
    m1_addr = v.m1_addr; m1_wr_data = v.m1_wd;
    @(negedge clk);
    if (sb.size() > 0) begin
      r = sb.pop_front();
      if (v.rst) begin
        chk("rst_drop_m0_vld", m0_rd_valid, 0);
        chk("rst_drop_m1_vld", m1_rd_valid, 0);
      end else begin
        chk("resp_m0_vld", m0_rd_valid, !r.own);
        chk("resp_m1_vld", m1_rd_valid, r.own);
        chk("resp_m0_data", m0_rd_data, r.own ? 32'h0 : r.data);
        chk("resp_m1_data", m1_rd_data, r.own ? r.data : 32'h0);
      end
    end else begin
      chk("idle_m0_vld", m0_rd_valid, 0);
      chk("idle_m1_vld", m1_rd_valid, 0);
    end
    chk("m0_gnt", m0_gnt, v.e_g0);
    chk("m1_gnt", m1_gnt, v.e_g1);
    chk("mem_en", mem_en, v.e_sel[0]);
    chk("gemm_en", gemm_en, v.e_sel[1]);
    chk("uart_sel", uart_sel, v.e_sel[2]);
    gnt = v.e_g0 | v.e_g1;
    rw   = v.e_g1 ? v.m1_rw   : v.m0_rw;
    mk_e = v.e_g1 ? v.m1_mask : v.m0_mask;
    wd_e = v.e_g1 ? v.m1_wd   : v.m0_wd;
    if (gnt) begin
      chk("bus_addr", bus_addr, v.e_addr);
      chk("bus_rdwr", bus_rdwr, rw);
      chk("bus_mask", bus_mask, mk_e);
      chk("bus_wr_data", bus_wr_data, wd_e);
      if (!rw) begin
        r.own = v.e_g1;
        r.data = v.e_sel[1] ? GEMM_D : (v.e_sel[2] ? UART_D : MEM_D);
        sb.push_back(r);
      end
    end
  endtask

  initial begin
    vec_t v;
    tbl[0]  = mk(1, 1, 0, 4'hF, 32'h10, 1, 0, 4'hF, 32'h20, 0, 0, S_NONE, 32'h0);
    tbl[1]  = mk(1, 0, 0, 4'h0, 32'h0, 0, 0, 4'h0, 32'h0, 0, 0, S_NONE, 32'h0);
    tbl[2]  = mk(0, 1, 0, 4'hF, 32'h10, 0, 0, 4'h0, 32'h0, 1, 0, S_MEM, 32'h10);
    tbl[3]  = idle();
    tbl[4]  = mk(0, 1, 1, 4'hF, 32'h9000_0004, 0, 0, 4'h0, 32'h0,
                 1, 0, S_GEMM, 32'h9000_0004);
    tbl[5]  = mk(0, 1, 1, 4'h3, 32'h8000_0000, 0, 0, 4'h0, 32'h0,
                 1, 0, S_UART, 32'h8000_0000);
    tbl[6]  = mk(0, 1, 1, 4'hC, 32'h0000_0400, 0, 0, 4'h0, 32'h0,
                 1, 0, S_MEM, 32'h0000_0400);
    tbl[7]  = idle();
    tbl[8]  = mk(0, 1, 0, 4'hF, 32'h9000_0000, 0, 0, 4'h0, 32'h0,
                 1, 0, S_GEMM, 32'h9000_0000);
    tbl[9]  = mk(0, 0, 0, 4'h0, 32'h0, 1, 0, 4'hF, 32'h8000_0000,
                 0, 1, S_UART, 32'h8000_0000);
    tbl[10] = idle();
    tbl[11] = mk(0, 0, 0, 4'h0, 32'h0, 1, 1, 4'b0010, 32'h7,
                 0, 1, S_MEM, 32'h4);
    tbl[12] = mk(0, 1, 0, 4'hF, 32'h20, 1, 0, 4'hF, 32'h30, 1, 0, S_MEM, 32'h20);
    tbl[13] = mk(0, 0, 0, 4'h0, 32'h0, 1, 0, 4'hF, 32'h30, 0, 1, S_MEM, 32'h30);
    tbl[14] = mk(0, 1, 0, 4'hF, 32'h9000_0003, 0, 0, 4'h0, 32'h0,
                 1, 0, S_GEMM, 32'h9000_0000);
    tbl[15] = mk(0, 1, 0, 4'hF, 32'h8000_0001, 0, 0, 4'h0, 32'h0,
                 1, 0, S_UART, 32'h8000_0000);
    tbl[16] = mk(0, 1, 0, 4'hF, 32'h0, 0, 0, 4'h0, 32'h0, 1, 0, S_MEM, 32'h0);
    tbl[17] = idle();

    for (int i = 0; i < 18; i++) apply(tbl[i]);

    // Contention: 8 m0 grants then one forced m1 grant, repeating
    for (int i = 0; i < 27; i++) begin
      if (i % 9 == 8)
        v = mk(0, 1, 0, 4'hF, 32'h40, 1, 0, 4'hF, 32'h9000_0010,
               0, 1, S_GEMM, 32'h9000_0010);
      else
        v = mk(0, 1, 0, 4'hF, 32'h40, 1, 0, 4'hF, 32'h9000_0010,
               1, 0, S_MEM, 32'h40);
      apply(v);
      n_cmp++;
      if (m0_gnt === 1'b1 && m1_gnt === 1'b1) begin
        n_err++;
        $display("FAIL one_hot_gnt: got both grants at cycle %0d", i);
      end
    end
    apply(idle());

    // Reset mid-read: pending m1 response must be dropped
    apply(mk(0, 0, 0, 4'h0, 32'h0, 1, 0, 4'hF, 32'h8000_0000,
             0, 1, S_UART, 32'h8000_0000));
    apply(mk(1, 1, 0, 4'hF, 32'h10, 1, 0, 4'hF, 32'h20, 0, 0, S_NONE, 32'h0));
    apply(idle());

    // Build the starvation count to its limit, then reset must clear it
    for (int i = 0; i < 8; i++)
      apply(mk(0, 1, 1, 4'hF, 32'h50, 1, 1, 4'hF, 32'h60, 1, 0, S_MEM, 32'h50));
    apply(mk(1, 1, 1, 4'hF, 32'h50, 1, 1, 4'hF, 32'h60, 0, 0, S_NONE, 32'h0));
    apply(mk(0, 1, 1, 4'hF, 32'h50, 1, 1, 4'hF, 32'h60, 1, 0, S_MEM, 32'h50));
    apply(idle());
    apply(idle());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
